multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath: shared memory, IR, register file, ALU and PC.
- It replaces the single-cycle combinational control unit in the processor top level.
- It decodes the 6-bit opcode held in the IR and steps the datapath through fetch, decode, execute, memory and writeback.
- Memory accesses stall on a ready handshake.

Parameters:
- OP_W, 6, opcode width
- ST_W, 4, state register width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_op  in  6  opcode from IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub (beq), 10 = funct (R-type), 11 = I-type (addi)
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Opcodes: R = 0, j = 2, beq = 4, addi = 8, lw = 35, sw = 43. All others are illegal.
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_RD = 4, MEM_WB = 5, MEM_WR = 6, EXEC = 7, R_WB = 8, BRANCH = 9, JUMP = 10, ADDI_EXEC = 11, ADDI_WB = 12. Codes 13–15 are unused and go to IDLE on the next edge.
- Reset: state = IDLE asynchronously. Every output is 0 in IDLE, including alu_src_b, alu_op and pc_source. state_dbg = 0.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH -> DECODE when mem_ready = 1; otherwise hold.
  - DECODE, by opcode: lw/sw -> MEM_ADDR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EXEC; illegal -> FETCH.
  - MEM_ADDR -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD -> MEM_WB when mem_ready = 1; otherwise hold.
  - MEM_WR -> FETCH when mem_ready = 1; otherwise hold.
  - EXEC -> R_WB. ADDI_EXEC -> ADDI_WB.
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB -> FETCH.
- Outputs per state (any output not listed is 0):
  - FETCH: mem_read = 1, alu_src_b = 01. ir_write and pc_write equal mem_ready (Mealy gating), so the PC increments exactly once per fetch regardless of wait states.
  - DECODE: alu_src_b = 11, alu_op = 00. illegal_op = 1 iff the opcode is unsupported.
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - MEM_RD: mem_read = 1, i_or_d = 1.
  - MEM_WB: mem_to_reg = 1, reg_write = 1, reg_dst = 0.
  - MEM_WR: mem_write = 1, i_or_d = 1.
  - EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - R_WB: reg_dst = 1, reg_write = 1.
  - BRANCH: alu_src_a = 1, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - JUMP: pc_write = 1, pc_source = 10.
  - ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 11.
  - ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
- Zero-wait latency, counted in cycles from FETCH entry to the next FETCH entry: R = 4, lw = 5, sw = 4, beq = 3, j = 3, addi = 4.
- mem_read and mem_write are never both 1. reg_write is never 1 while any memory request is active.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- instr_op is sampled only in DECODE.
- Reset asserted mid-instruction: state returns to IDLE and outputs go to 0 immediately, asynchronously, with no partial writeback.
- All other outputs, including state_dbg, decode from the state register alone.

Decomposition:
- Shared include mips_defs.vh holds:
  - opcode localparams (OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW)
  - ALU_OP_* encodings
  - ALUSRCB_* and PCSRC_* encodings
  - state localparams
- The single-cycle control unit uses the same constants.
- One sub-module is natural: multicycle_control_outdec, a combinational state -> control-word decoder. The FSM owns next-state logic and the mem_ready gating.

Test Plan:
- Reset then release, mem_ready = 1, instr_op = 0 -> state_dbg sequence 0, 1, 2, 7, 8, 1. In R_WB: reg_dst = 1, reg_write = 1, alu_op was 2 in EXEC.
- instr_op = 35, mem_ready held 0 for 2 cycles in FETCH and 2 in MEM_RD -> pc_write high exactly one cycle. Path 1, 2, 3, 4, 5, 1. In MEM_WB: mem_to_reg = 1, reg_write = 1, reg_dst = 0.
- instr_op = 43 -> path 1, 2, 3, 6, 1. In MEM_WR: mem_write = 1, i_or_d = 1, reg_write = 0. alu_op = 0 in MEM_ADDR.
- instr_op = 4 then 8 -> beq: BRANCH with pc_write_cond = 1, alu_op = 1, pc_source = 1. addi: ADDI_EXEC with alu_op = 3, alu_src_b = 2, then ADDI_WB with reg_write = 1.
- instr_op = 63 -> illegal_op pulses for exactly one cycle in DECODE, next state FETCH, no reg_write or mem_write asserted.
- rst_n driven low during MEM_WB of a lw -> all outputs 0 within the same cycle. After release the path restarts 0, 1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller.
// The single-cycle control unit uses the same opcode and select encodings.
package multicycle_control_pkg;

   // Opcodes, taken from IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   // ALU operation class handed to the ALU control
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

   // ALU B-operand select
   localparam logic [1:0] ALUSRCB_B       = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Controller states; codes 13..15 are unused and recover to IDLE
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_RD    = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WR    = 4'd6,
      ST_EXEC      = 4'd7,
      ST_R_WB      = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_ADDI_EXEC = 4'd11,
      ST_ADDI_WB   = 4'd12
   } state_e;

   // Moore control word decoded from the state register alone.
   // 'fetch' marks the state whose IR/PC loads are gated by mem_ready.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       fetch;
   } ctrl_t;

   // True for the opcodes this datapath implements
   function automatic logic op_is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
             (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Combinational state -> control-word decoder for the multi-cycle controller.
module multicycle_control_outdec
   import multicycle_control_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);

   // Everything defaults to 0, so IDLE and unused codes drive a quiet datapath
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = ALUSRCB_FOUR;
            ctrl_o.fetch     = 1'b1;
         end
         ST_DECODE: begin
            ctrl_o.alu_src_b = ALUSRCB_IMM_SH2;
            ctrl_o.alu_op    = ALU_OP_ADD;
         end
         ST_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUSRCB_IMM;
            ctrl_o.alu_op    = ALU_OP_ADD;
         end
         ST_MEM_RD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         ST_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUSRCB_B;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
         end
         ST_R_WB: begin
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_op        = ALU_OP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
         end
         ST_ADDI_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUSRCB_IMM;
            ctrl_o.alu_op    = ALU_OP_ITYPE;
         end
         ST_ADDI_WB: begin
            ctrl_o.reg_write = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: state register, next-state logic and the
// mem_ready gating of the fetch-time IR/PC loads.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int ST_W = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] instr_op,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            i_or_d,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            mem_to_reg,
   output logic            reg_dst,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_source,
   output logic            illegal_op,
   output logic [ST_W-1:0] state_dbg
);

   state_e state_q, state_d;
   // Remembers lw vs sw from DECODE so the opcode is only looked at there
   logic   is_store_q, is_store_d;
   ctrl_t  ctrl;
   logic   op_legal;

   assign op_legal = op_is_legal(instr_op[5:0]);

   // State register; reset drops straight back to IDLE, aborting any writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         is_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
      end
   end

   // Next-state selection; mem_ready matters only in the three memory states
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      case (state_q)
         ST_IDLE:   state_d = ST_FETCH;
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            is_store_d = (instr_op[5:0] == OP_SW);
            case (instr_op[5:0])
               OP_LW, OP_SW: state_d = ST_MEM_ADDR;
               OP_RTYPE:     state_d = ST_EXEC;
               OP_BEQ:       state_d = ST_BRANCH;
               OP_J:         state_d = ST_JUMP;
               OP_ADDI:      state_d = ST_ADDI_EXEC;
               default:      state_d = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR:  state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:    if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WR:    if (mem_ready) state_d = ST_FETCH;
         ST_EXEC:      state_d = ST_R_WB;
         ST_ADDI_EXEC: state_d = ST_ADDI_WB;
         ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                       state_d = ST_FETCH;
         default:      state_d = ST_IDLE;
      endcase
   end

   multicycle_control_outdec u_outdec (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   // IR and PC load only in the fetch cycle the memory completes, so wait
   // states never advance the PC more than once per instruction
   assign ir_write      = ctrl.fetch & mem_ready;
   assign pc_write      = ctrl.pc_write | (ctrl.fetch & mem_ready);
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign illegal_op    = (state_q == ST_DECODE) && !op_legal;
   assign state_dbg     = ST_W'(state_q);

endmodule
